ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 103 ++++++++++
 tb/tb_ram_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 16x16 RAM.
// Each accepted request runs a fixed IDLE -> ACCESS -> RESP sequence.
module ram_arbiter #(
  parameter int width = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_a,
  input  logic           req_b,
  input  logic           we_a,
  input  logic           we_b,
  input  logic [3:0]     addr_a,
  input  logic [3:0]     addr_b,
  input  logic [width:0] wdata_a,
  input  logic [width:0] wdata_b,
  output logic           gnt_a,
  output logic           gnt_b,
  output logic           done_a,
  output logic           done_b,
  output logic [width:0] rdata_a,
  output logic [width:0] rdata_b,
  output logic           busy,
  output logic           ram_write_en,
  output logic [3:0]     ram_addr,
  output logic [width:0] ram_data_in,
  input  logic [width:0] ram_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   last_b_q;
  logic   win_b_q;
  logic   we_q;
  logic   take;
  logic   pick_a;

  // next state and arbitration decision
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    pick_a  = req_a && (!req_b || last_b_q);
    unique case (state_q)
      IDLE: begin
        take = req_a || req_b;
        if (take) state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, latched request and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_b_q     <= 1'b1;
      win_b_q      <= 1'b0;
      we_q         <= 1'b0;
      gnt_a        <= 1'b0;
      gnt_b        <= 1'b0;
      done_a       <= 1'b0;
      done_b       <= 1'b0;
      rdata_a      <= '0;
      rdata_b      <= '0;
      ram_write_en <= 1'b0;
      ram_addr     <= '0;
      ram_data_in  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_a        <= 1'b0;
      gnt_b        <= 1'b0;
      done_a       <= 1'b0;
      done_b       <= 1'b0;
      ram_write_en <= 1'b0;
      if (take) begin
        win_b_q      <= !pick_a;
        last_b_q     <= !pick_a;
        gnt_a        <= pick_a;
        gnt_b        <= !pick_a;
        we_q         <= pick_a ? we_a : we_b;
        ram_write_en <= pick_a ? we_a : we_b;
        ram_addr     <= pick_a ? addr_a : addr_b;
        ram_data_in  <= pick_a ? wdata_a : wdata_b;
      end
      if (state_q == RESP) begin
        done_a <= !win_b_q;
        done_b <= win_b_q;
        if (!we_q && !win_b_q) rdata_a <= ram_data_out;
        if (!we_q && win_b_q)  rdata_b <= ram_data_out;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural RAM and
// a transaction-level reference model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 0, req_b = 0, we_a = 0, we_b = 0;
  logic [3:0]  addr_a = 0, addr_b = 0;
  logic [15:0] wdata_a = 0, wdata_b = 0;
  logic        gnt_a, gnt_b, done_a, done_b, busy;
  logic [15:0] rdata_a, rdata_b;
  logic        ram_write_en;
  logic [3:0]  ram_addr;
  logic [15:0] ram_data_in;
  logic [15:0] ram_data_out;

  ram_arbiter #(.width(15)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b),
    .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .done_a(done_a), .done_b(done_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .busy(busy),
    .ram_write_en(ram_write_en),
    .ram_addr(ram_addr),
    .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic void chk(input string n,
                              input logic [31:0] a,
                              input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               n, a, e, cyc);
    end
  endfunction

  // RAM behaviour: the arbiter's reset also blocks a pending write
  logic [15:0] ram [16];
  logic [15:0] ref_mem [16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]     = 16'h1000 + 16'(i);
      ref_mem[i] = 16'h1000 + 16'(i);
    end
    ram_data_out = '0;
  end

  always @(posedge clk) begin
    if (ram_write_en && !rst) ram[ram_addr] <= ram_data_in;
    if (!ram_write_en) ram_data_out <= ram[ram_addr];
  end

  // input snapshot at each rising edge
  logic        rst_s, pa, pb, swa, swb;
  logic [3:0]  saa, sab;
  logic [15:0] sda, sdb;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
    pa    <= req_a;
    pb    <= req_b;
    swa   <= we_a;
    swb   <= we_b;
    saa   <= addr_a;
    sab   <= addr_b;
    sda   <= wdata_a;
    sdb   <= wdata_b;
  end

  typedef struct {
    bit          side;
    bit          we;
    logic [3:0]  addr;
    logic [15:0] wd;
    int          gcyc;
  } txn_t;

  txn_t        q[$];
  bit          last_b = 1'b1;
  int          busy_cnt = 0;
  logic [15:0] mrd_a = '0;
  logic [15:0] mrd_b = '0;

  // monitor: reference model and output comparison
  initial begin
    forever begin
      @(negedge clk);
      if (rst_s) begin
        q.delete();
        last_b   = 1'b1;
        busy_cnt = 0;
        mrd_a    = '0;
        mrd_b    = '0;
        chk("rst_pulses",
            {gnt_a, gnt_b, done_a, done_b, busy, ram_write_en}, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_data_in, 0);
        chk("rst_rdata_a", rdata_a, 0);
        chk("rst_rdata_b", rdata_b, 0);
      end else begin
        bit exp_d;
        bit exp_g;
        bit win;
        txn_t t;
        if (q.size() != 0 && q[0].we && q[0].gcyc + 1 == cyc)
          ref_mem[q[0].addr] = q[0].wd;
        exp_d = (q.size() != 0) && (q[0].gcyc + 2 == cyc);
        chk("done_any", done_a | done_b, exp_d);
        chk("done_excl", done_a & done_b, 0);
        if (exp_d) begin
          t = q.pop_front();
          chk("done_side", done_b, t.side);
          if (!t.we) begin
            if (t.side) mrd_b = ref_mem[t.addr];
            else        mrd_a = ref_mem[t.addr];
          end
        end
        chk("rdata_a", rdata_a, mrd_a);
        chk("rdata_b", rdata_b, mrd_b);
        exp_g = (busy_cnt == 0) && (pa || pb);
        if (busy_cnt > 0) busy_cnt--;
        chk("gnt_any", gnt_a | gnt_b, exp_g);
        chk("gnt_excl", gnt_a & gnt_b, 0);
        if (exp_g) begin
          win = (pa && pb) ? !last_b : pb;
          chk("gnt_winner", gnt_b, win);
          last_b   = win;
          busy_cnt = 2;
          t.side = win;
          t.we   = win ? swb : swa;
          t.addr = win ? sab : saa;
          t.wd   = win ? sdb : sda;
          t.gcyc = cyc;
          q.push_back(t);
          chk("acc_we", ram_write_en, t.we);
          chk("acc_addr", ram_addr, t.addr);
          if (t.we) chk("acc_din", ram_data_in, t.wd);
        end else begin
          chk("we_idle", ram_write_en, 0);
        end
        chk("busy", busy, q.size() != 0);
      end
    end
  end

  task automatic request(input bit side, input bit we,
                         input logic [3:0] addr,
                         input logic [15:0] wd);
    bit got = 0;
    if (side) begin
      we_b = we; addr_b = addr; wdata_b = wd; req_b = 1;
    end else begin
      we_a = we; addr_a = addr; wdata_a = wd; req_a = 1;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = side ? gnt_b : gnt_a;
    end
    chk(side ? "gnt_wait_b" : "gnt_wait_a", got, 1);
    if (side) req_b = 0;
    else      req_a = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1;
    idle(2);
    rst = 0;
  endtask

  task automatic rand_loop(input bit side, input int n);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 4));
      request(side, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)),
              16'($urandom));
    end
  endtask

  initial begin
    idle(3);
    rst = 0;
    idle(2);
    // write then read back on A
    request(0, 1, 4'd4, 16'hAAAA);
    idle(4);
    request(0, 0, 4'd4, 16'h0);
    idle(4);
    // simultaneous requests from reset
    pulse_rst();
    fork
      request(0, 1, 4'd9, 16'h005D);
      request(1, 1, 4'd10, 16'hCCCC);
    join
    idle(4);
    // back-to-back contention
    fork
      begin
        for (int i = 0; i < 3; i++) request(0, 0, 4'(i), 16'h0);
      end
      begin
        for (int i = 0; i < 3; i++) request(1, 1, 4'(i + 5), 16'h5A00);
      end
    join
    idle(4);
    // reset while a write to 15 sits in ACCESS
    request(0, 1, 4'd15, 16'hFFFF);
    rst = 1;
    idle(1);
    rst = 0;
    idle(2);
    request(0, 0, 4'd15, 16'h0);
    idle(4);
    // B alone reads address 0
    request(1, 0, 4'd0, 16'h0);
    idle(4);
    // random contention
    fork
      rand_loop(0, 25);
      rand_loop(1, 25);
    join
    idle(8);
    chk("drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
